pe_mac_acc: RTL
===============

Name: pe_mac_acc

Overview:
- Parametrised systolic-array processing element, successor to the single-cycle multiply-add PE.
- Generic data/accumulator widths, signed/unsigned select, saturation, valid/last sideband and a programmable mode: output-stationary (local accumulate) or weight-stationary (psum pass-down).
- Tiles into an R x C grid: a flows east, b/psum flows south; the array controller drives mode, clear and result-drain handshake.

Parameters:
- DW, 16, width of a and b operands
- AW, 40, accumulator/psum width (must be >= 2*DW)
- SIGNED, 1, 1 = two's-complement multiply, 0 = unsigned
- SAT, 1, 1 = saturate accumulator at AW limits, 0 = wrap modulo 2^AW

Ports:
- clk  in  1  clock, posedge only
- rst  in  1  reset, synchronous, active-high
- mode  in  1  0 = output-stationary (OS), 1 = weight-stationary (WS); sampled only in IDLE
- a_in  in  DW  west operand
- b_in  in  DW  north operand (OS) / weight load value (WS)
- psum_in  in  AW  north partial sum (WS only)
- in_valid  in  1  a_in/b_in/psum_in valid this cycle
- in_last  in  1  final element of current dot product (OS)
- w_load  in  1  WS: latch b_in as stationary weight
- a_out  out  DW  registered a_in to east neighbour
- b_out  out  DW  registered b_in to south neighbour
- psum_out  out  AW  WS: registered psum_in + a_in*w
- out_valid  out  1  registered in_valid
- out_last  out  1  registered in_last
- res_out  out  AW  OS: completed dot product
- res_valid  out  1  res_out held valid
- res_ready  in  1  consumer accepts res_out
- ovf  out  1  sticky: saturation/wrap occurred or a result was dropped

Behaviour:
- All state updates on posedge clk. rst=1 (synchronous): every output 0, accumulator 0, weight 0, state IDLE; overrides all other inputs that cycle.
- Passthrough: a_out<=a_in, b_out<=b_in, out_valid<=in_valid, out_last<=in_last every cycle regardless of mode/state; latency 1.
- Product p = a_in*b_in (OS) or a_in*w (WS), 2*DW bits, sign- or zero-extended to AW per SIGNED.
- Addition: AW+1-bit intermediate. SAT=1: clamp to max/min representable (signed or unsigned) and set ovf. SAT=0: truncate to AW; ovf set on carry-out/signed overflow.
- FSM states: IDLE, OS_ACC, WS_RUN.
- IDLE: mode=0 and in_valid -> OS_ACC; acc<=p, or emit immediately if in_last. mode=1 -> WS_RUN. Mode changes outside IDLE are ignored.
- OS_ACC: each in_valid does acc<=acc+p. in_valid && in_last: res_out<=acc+p, res_valid<=1, acc<=0, next state IDLE. in_valid=0 holds acc.
- Result handshake: res_valid stays 1 until the cycle res_ready=1, then clears next cycle. A new last arriving while res_valid=1 and res_ready=0: new result dropped, old result held, ovf<=1. Same-cycle res_ready=1 and new last: new result replaces, res_valid stays 1.
- WS_RUN: w_load=1 -> w<=b_in (psum_out not updated that cycle). in_valid && !w_load -> psum_out<=psum_in+p, latency 1. Returns to IDLE only on rst.
- Both w_load and in_valid in the same cycle: load wins; in_valid is still forwarded on out_valid.
- ovf clears only on rst.

Decomposition:
- Shared package pe_pkg: mode encoding constants (MODE_OS=0, MODE_WS=1), FSM state typedef, saturating-add function parameterised by AW/SIGNED.
- One sub-module, pe_sat_add (AW-bit add with clamp/wrap and overflow flag). Shared by OS and WS paths, so one adder instance is selected by state.

Test Plan:
- Reset: drive random inputs with rst=1 for 3 cycles -> all outputs 0, state IDLE; rst asserted mid-OS accumulation -> acc and res_valid 0 next cycle.
- OS dot product (DW=16, SIGNED=1): a={3,-4,5}, b={2,6,-1}, last on 3rd, res_ready=1 -> res_out=-23, res_valid for one cycle, 1 cycle after last.
- Backpressure: two back-to-back 1-element products (7*7 then 2*2) with res_ready=0 -> res_out stays 49, ovf=1; raise res_ready -> res_valid drops next cycle.
- Saturation (SAT=1, AW=32, signed): accumulate 0x7FFF*0x7FFF repeatedly 5 times -> res_out=0x7FFFFFFF, ovf=1; SAT=0 same stimulus -> wrapped value mod 2^32.
- WS: w_load with b_in=-3, then a_in=4, psum_in=100 -> psum_out=88 one cycle later; w_load and in_valid same cycle -> weight updated, psum_out unchanged.
- Passthrough: any mode, a_in=0x1234, b_in=0xABCD, in_valid=1, in_last=1 -> a_out/b_out/out_valid/out_last equal inputs exactly 1 cycle later.

Source files
------------

// File: rtl/pe_pkg.sv
// Shared definitions for the systolic processing element: mode encoding,
// FSM state type and the overflow rule used by the accumulator adder.
package pe_pkg;

   localparam logic MODE_OS = 1'b0;
   localparam logic MODE_WS = 1'b1;

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      OS_ACC = 2'd1,
      WS_RUN = 2'd2
   } pe_state_t;

   // Signed overflow: like-signed operands give an opposite-signed sum; unsigned: carry out.
   function automatic logic add_overflow(input logic is_signed,
                                         input logic a_msb,
                                         input logic b_msb,
                                         input logic s_msb,
                                         input logic carry);
      if (is_signed)
         return (a_msb == b_msb) && (s_msb != a_msb);
      else
         return carry;
   endfunction

endpackage

// File: rtl/pe_sat_add.sv
// AW-bit adder with an AW+1-bit intermediate; clamps to the representable
// limit when SAT=1, otherwise wraps. ovf flags the out-of-range condition.
module pe_sat_add
   import pe_pkg::*;
#(
   parameter int AW     = 40,
   parameter bit SIGNED = 1'b1,
   parameter bit SAT    = 1'b1
) (
   input  logic [AW-1:0] a,
   input  logic [AW-1:0] b,
   output logic [AW-1:0] sum,
   output logic          ovf
);

   logic [AW:0]   wide;
   logic [AW-1:0] clamp;

   // The limit we clamp to follows the sign of the operands that overflowed.
   always_comb begin
      wide = {1'b0, a} + {1'b0, b};
      ovf  = add_overflow(SIGNED, a[AW-1], b[AW-1], wide[AW-1], wide[AW]);
      if (SIGNED)
         clamp = a[AW-1] ? {1'b1, {(AW-1){1'b0}}} : {1'b0, {(AW-1){1'b1}}};
      else
         clamp = '1;
      sum = (SAT && ovf) ? clamp : wide[AW-1:0];
   end

endmodule

// File: rtl/pe_mac_acc.sv
// Systolic-array PE: output-stationary dot-product accumulation with a result
// handshake, or weight-stationary psum pass-down; operands forwarded east/south.
module pe_mac_acc
   import pe_pkg::*;
#(
   parameter int DW     = 16,
   parameter int AW     = 40,
   parameter bit SIGNED = 1'b1,
   parameter bit SAT    = 1'b1
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          mode,
   input  logic [DW-1:0] a_in,
   input  logic [DW-1:0] b_in,
   input  logic [AW-1:0] psum_in,
   input  logic          in_valid,
   input  logic          in_last,
   input  logic          w_load,
   output logic [DW-1:0] a_out,
   output logic [DW-1:0] b_out,
   output logic [AW-1:0] psum_out,
   output logic          out_valid,
   output logic          out_last,
   output logic [AW-1:0] res_out,
   output logic          res_valid,
   input  logic          res_ready,
   output logic          ovf
);

   pe_state_t       state;
   logic [AW-1:0]   acc;
   logic [DW-1:0]   w;
   logic [DW-1:0]   mul_b;
   logic [2*DW-1:0] prod;
   logic [AW-1:0]   prod_ext;
   logic [AW-1:0]   add_a;
   logic [AW-1:0]   add_sum;
   logic            add_ovf;
   logic            add_used;
   logic            emit_res;

   // One multiplier and one adder serve both modes; state picks the operands.
   always_comb begin
      mul_b    = (state == WS_RUN) ? w : b_in;
      add_a    = '0;
      add_used = 1'b0;
      emit_res = 1'b0;
      case (state)
         IDLE: begin
            add_used = in_valid && (mode == MODE_OS);
            emit_res = add_used && in_last;
         end
         OS_ACC: begin
            add_a    = acc;
            add_used = in_valid;
            emit_res = in_valid && in_last;
         end
         WS_RUN: begin
            add_a    = psum_in;
            add_used = in_valid && !w_load;
         end
         default: ;
      endcase
   end

   generate
      if (SIGNED) begin : g_signed
         assign prod     = (2*DW)'($signed(a_in)) * (2*DW)'($signed(mul_b));
         assign prod_ext = AW'($signed(prod));
      end else begin : g_unsigned
         assign prod     = (2*DW)'(a_in) * (2*DW)'(mul_b);
         assign prod_ext = AW'(prod);
      end
   endgenerate

   pe_sat_add #(
      .AW    (AW),
      .SIGNED(SIGNED),
      .SAT   (SAT)
   ) u_add (
      .a  (add_a),
      .b  (prod_ext),
      .sum(add_sum),
      .ovf(add_ovf)
   );

   // A pending unaccepted result is never overwritten; a new one is dropped and flagged.
   always_ff @(posedge clk) begin
      if (rst) begin
         state     <= IDLE;
         acc       <= '0;
         w         <= '0;
         a_out     <= '0;
         b_out     <= '0;
         psum_out  <= '0;
         out_valid <= 1'b0;
         out_last  <= 1'b0;
         res_out   <= '0;
         res_valid <= 1'b0;
         ovf       <= 1'b0;
      end else begin
         a_out     <= a_in;
         b_out     <= b_in;
         out_valid <= in_valid;
         out_last  <= in_last;

         if (res_valid && res_ready)
            res_valid <= 1'b0;
         if (add_used && add_ovf)
            ovf <= 1'b1;

         case (state)
            IDLE: begin
               if (mode == MODE_WS) begin
                  state <= WS_RUN;
               end else if (in_valid && !in_last) begin
                  acc   <= add_sum;
                  state <= OS_ACC;
               end
            end
            OS_ACC: begin
               if (in_valid) begin
                  if (in_last) begin
                     acc   <= '0;
                     state <= IDLE;
                  end else begin
                     acc <= add_sum;
                  end
               end
            end
            WS_RUN: begin
               if (w_load)
                  w <= b_in;
               else if (in_valid)
                  psum_out <= add_sum;
            end
            default: state <= IDLE;
         endcase

         if (emit_res) begin
            if (res_valid && !res_ready) begin
               ovf <= 1'b1;
            end else begin
               res_out   <= add_sum;
               res_valid <= 1'b1;
            end
         end
      end
   end

endmodule
